prbs_test_ctrl: RTL
===================

PRBS_TEST_CTRL -- requirements
Module: prbs_test_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, width of the PRBS word and of the checker error vector.
REQ-002 The block SHALL have parameter LOCK_WORDS, default 64, the number of consecutive error-free words required to declare lock.
REQ-003 The block SHALL have parameter UNLOCK_WORDS, default 8, the number of consecutive errored words in RUN that declares loss of lock.
REQ-004 The block SHALL have parameter ACQ_TIMEOUT, default 4096, the number of clk cycles allowed in ACQ before acquisition fails.
REQ-005 Ports, with one clock and reset asynchronous, active-high:
  clk  input  1  sole clock, rising edge
  rst  input  1  asynchronous, active-high reset
  start  input  1  one-cycle request to begin a test; honoured only in IDLE
  abort  input  1  level; forces return to IDLE
  test_len  input  32  RUN word count, sampled at start; 0 = run until abort
  gen_rst  output  1  synchronous reset to the PRBS generator
  gen_en  output  1  generator advance enable
  chk_rst  output  1  synchronous reset to the PRBS checker
  chk_en  output  1  checker advance enable, equal to chk_valid while in ACQ or RUN
  chk_valid  input  1  received word present at the checker input this cycle
  chk_err  input  DATA_WIDTH  checker output word; 0 = match, each 1 = bit error
  chk_err_vld  input  1  chk_err is valid this cycle (checker enable delayed one cycle)
  busy  output  1  high in any state other than IDLE
  locked  output  1  high only in RUN
  done  output  1  one-cycle pulse on entering DONE
  acq_fail  output  1  sticky; set on ACQ timeout
  lock_loss  output  1  sticky; set on RUN-to-ACQ fallback
  word_cnt  output  32  words checked in RUN
  err_cnt  output  32  bit errors counted in RUN, saturating

Function
REQ-006 The FSM SHALL have the states IDLE, INIT, ACQ, RUN and DONE.
REQ-007 IDLE SHALL go to INIT on start=1 and abort=0, latch test_len, and clear word_cnt, err_cnt, acq_fail and lock_loss in that same cycle.
REQ-008 INIT SHALL last exactly 2 cycles with gen_rst=1 and chk_rst=1, then go to ACQ.
REQ-009 gen_en SHALL be 1 in ACQ and RUN and 0 in every other state.
REQ-010 In ACQ, on each chk_err_vld with chk_err==0 the consecutive-good counter SHALL increment; on chk_err!=0 it SHALL clear to 0.
REQ-011 When the consecutive-good counter reaches LOCK_WORDS, ACQ SHALL go to RUN on the next cycle with the counter cleared; word_cnt and err_cnt SHALL NOT count in ACQ.
REQ-012 The ACQ cycle counter SHALL clear on ACQ entry; on reaching ACQ_TIMEOUT it SHALL set acq_fail and go to DONE.
REQ-013 In RUN, each chk_err_vld SHALL add 1 to word_cnt and popcount(chk_err) to err_cnt, and err_cnt SHALL saturate at 32'hFFFF_FFFF.
REQ-014 In RUN, the consecutive-errored-word counter SHALL increment on chk_err!=0 and clear on chk_err==0; on reaching UNLOCK_WORDS it SHALL set lock_loss, pulse chk_rst for 1 cycle, and return to ACQ while keeping word_cnt and err_cnt.
REQ-015 In RUN with latched test_len!=0, the cycle where word_cnt becomes test_len SHALL be counted and the FSM SHALL go to DONE next; when the unlock and length conditions coincide, DONE SHALL win.
REQ-016 DONE SHALL assert done for 1 cycle and go to IDLE; counters and sticky flags SHALL hold until the next accepted start.
REQ-017 abort=1 SHALL force IDLE on the next clock from any state, without a done pulse, with counters held; abort SHALL take priority over start and every other transition.
REQ-018 start outside IDLE SHALL be ignored.
REQ-019 Every output SHALL be registered.

Reset
REQ-020 rst=1 SHALL immediately force IDLE and zero every output and internal counter, regardless of clk.
REQ-021 Deassertion of rst SHALL take effect at the next rising clk edge; a start on the first post-reset cycle SHALL be accepted.

Verification
REQ-022 Clean loop (generator into checker), test_len=1000, chk_valid=1 -> busy 1 cycle after start, INIT 2 cycles, locked after 64 clean words, done pulse once word_cnt=1000, err_cnt=0.
REQ-023 Single-bit error injected every 100th RUN word, test_len=1000 -> err_cnt=10, lock_loss=0, word_cnt=1000.
REQ-024 Invert all bits for 8 consecutive RUN words -> err_cnt increments by 128, lock_loss=1, locked drops, chk_rst 1-cycle pulse, relock after 64 clean words.
REQ-025 chk_err stuck at 16'h0001 in ACQ -> acq_fail=1 and done after 4096 ACQ cycles, locked never 1.
REQ-026 Abort at word 500 of RUN, then rst mid-ACQ on a second test -> IDLE with no done pulse and word_cnt=500 held; after rst all outputs 0.
REQ-027 chk_err=16'hFFFF at err_cnt=32'hFFFF_FFF0 -> err_cnt saturates at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/prbs_test_ctrl_if.sv
// Control, status and checker-side signals of the PRBS test controller.
// master drives the controller (host + checker); slave is the controller itself.
interface prbs_test_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  start;
  logic                  abort;
  logic [31:0]           test_len;
  logic                  gen_rst;
  logic                  gen_en;
  logic                  chk_rst;
  logic                  chk_en;
  logic                  chk_valid;
  logic [DATA_WIDTH-1:0] chk_err;
  logic                  chk_err_vld;
  logic                  busy;
  logic                  locked;
  logic                  done;
  logic                  acq_fail;
  logic                  lock_loss;
  logic [31:0]           word_cnt;
  logic [31:0]           err_cnt;

  modport master (
    output start, abort, test_len, chk_valid, chk_err, chk_err_vld,
    input  gen_rst, gen_en, chk_rst, chk_en, busy, locked, done,
           acq_fail, lock_loss, word_cnt, err_cnt
  );

  modport slave (
    input  start, abort, test_len, chk_valid, chk_err, chk_err_vld,
    output gen_rst, gen_en, chk_rst, chk_en, busy, locked, done,
           acq_fail, lock_loss, word_cnt, err_cnt
  );
endinterface

// File: rtl/prbs_test_ctrl.sv
// PRBS link test sequencer: resets generator/checker, acquires lock, counts
// words and bit errors in RUN, detects loss of lock and acquisition timeout.
module prbs_test_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int LOCK_WORDS   = 64,
  parameter int UNLOCK_WORDS = 8,
  parameter int ACQ_TIMEOUT  = 4096
) (
  input  logic             clk,
  input  logic             rst,
  prbs_test_ctrl_if.slave  ctl
);

  typedef enum logic [2:0] {IDLE, INIT, ACQ, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic        init_cnt;
  logic [31:0] good_cnt;
  logic [31:0] bad_cnt;
  logic [31:0] acq_cyc;
  logic [31:0] len_q;
  logic        word_vld;
  logic        word_bad;
  logic        len_hit;
  logic        unlock_hit;
  logic        start_acc;

  function automatic logic [31:0] popcount(input logic [DATA_WIDTH-1:0] e);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < DATA_WIDTH; i++) n = n + 32'(e[i]);
    return n;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // RUN words are ignored on the cycle abort is applied so counters hold as-is
  assign word_vld   = (state == RUN) && ctl.chk_err_vld && !ctl.abort;
  assign word_bad   = |ctl.chk_err;
  assign len_hit    = word_vld && (len_q != 32'd0) && (ctl.word_cnt + 32'd1 == len_q);
  assign unlock_hit = word_vld && word_bad && (bad_cnt + 32'd1 == 32'(UNLOCK_WORDS));
  assign start_acc  = (state == IDLE) && ctl.start && !ctl.abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ctl.start) state_nxt = INIT;
      INIT: if (init_cnt) state_nxt = ACQ;
      ACQ: begin
        if (good_cnt == 32'(LOCK_WORDS))             state_nxt = RUN;
        else if (acq_cyc == 32'(ACQ_TIMEOUT - 1))    state_nxt = DONE;
      end
      RUN: begin
        if (len_hit)         state_nxt = DONE;
        else if (unlock_hit) state_nxt = ACQ;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (ctl.abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt      <= 1'b0;
      good_cnt      <= '0;
      bad_cnt       <= '0;
      acq_cyc       <= '0;
      len_q         <= '0;
      ctl.gen_rst   <= 1'b0;
      ctl.gen_en    <= 1'b0;
      ctl.chk_rst   <= 1'b0;
      ctl.chk_en    <= 1'b0;
      ctl.busy      <= 1'b0;
      ctl.locked    <= 1'b0;
      ctl.done      <= 1'b0;
      ctl.acq_fail  <= 1'b0;
      ctl.lock_loss <= 1'b0;
      ctl.word_cnt  <= '0;
      ctl.err_cnt   <= '0;
    end else begin
      init_cnt <= (state == INIT) ? !init_cnt : 1'b0;

      if (state == ACQ && state_nxt == ACQ) begin
        acq_cyc <= acq_cyc + 32'd1;
        if (ctl.chk_err_vld) good_cnt <= word_bad ? 32'd0 : good_cnt + 32'd1;
      end else begin
        acq_cyc  <= '0;
        good_cnt <= '0;
      end

      if (state != RUN || state_nxt != RUN) bad_cnt <= '0;
      else if (word_vld)                    bad_cnt <= word_bad ? bad_cnt + 32'd1 : 32'd0;

      if (start_acc) begin
        len_q         <= ctl.test_len;
        ctl.word_cnt  <= '0;
        ctl.err_cnt   <= '0;
        ctl.acq_fail  <= 1'b0;
        ctl.lock_loss <= 1'b0;
      end else begin
        if (word_vld) begin
          ctl.word_cnt <= ctl.word_cnt + 32'd1;
          ctl.err_cnt  <= sat_add(ctl.err_cnt, popcount(ctl.chk_err));
        end
        if (state == ACQ && state_nxt == DONE) ctl.acq_fail  <= 1'b1;
        if (state == RUN && state_nxt == ACQ)  ctl.lock_loss <= 1'b1;
      end

      // Outputs are registered from the next state so they align with it
      ctl.busy    <= (state_nxt != IDLE);
      ctl.locked  <= (state_nxt == RUN);
      ctl.done    <= (state_nxt == DONE);
      ctl.gen_rst <= (state_nxt == INIT);
      ctl.chk_rst <= (state_nxt == INIT) || (state == RUN && state_nxt == ACQ);
      ctl.gen_en  <= (state_nxt == ACQ) || (state_nxt == RUN);
      ctl.chk_en  <= ctl.chk_valid && ((state_nxt == ACQ) || (state_nxt == RUN));
    end
  end

endmodule
